// File: rtl/ex_issue_reg.sv
// ID/EX issue register: holds one decoded instruction, resolves its source operands
// through MEM/WB forwarding, and inserts a bubble on a load-use dependency.
module ex_issue_reg #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_opcode,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [REGW-1:0] in_rd,
   input  logic [XLEN-1:0] in_rs1_val,
   input  logic [XLEN-1:0] in_rs2_val,
   input  logic [XLEN-1:0] in_imm,
   input  logic            in_use_imm,
   input  logic            in_is_load,
   input  logic            flush,
   input  logic            mem_fwd_valid,
   input  logic [REGW-1:0] mem_fwd_rd,
   input  logic [XLEN-1:0] mem_fwd_data,
   input  logic            wb_fwd_valid,
   input  logic [REGW-1:0] wb_fwd_rd,
   input  logic [XLEN-1:0] wb_fwd_data,
   input  logic            out_ready,
   output logic            ex_valid,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   output logic [3:0]      alu_opcode,
   output logic [REGW-1:0] ex_rd,
   output logic            ex_is_load,
   output logic [15:0]     bubble_count
);

   logic            valid_reg;
   logic [3:0]      opcode_reg;
   logic [REGW-1:0] rs1_reg;
   logic [REGW-1:0] rs2_reg;
   logic [REGW-1:0] rd_reg;
   logic [XLEN-1:0] rs1_val_reg;
   logic [XLEN-1:0] rs2_val_reg;
   logic [XLEN-1:0] imm_reg;
   logic            use_imm_reg;
   logic            is_load_reg;
   logic [15:0]     bubble_count_reg;

   logic [REGW-1:0] src_idx [2];
   logic [XLEN-1:0] src_val [2];
   logic [XLEN-1:0] src_res [2];

   logic hazard;
   logic accept;

   assign src_idx[0] = rs1_reg;
   assign src_idx[1] = rs2_reg;
   assign src_val[0] = rs1_val_reg;
   assign src_val[1] = rs2_val_reg;

   // Register x0 is hard-wired, so index 0 never picks up forwarded data; MEM beats WB.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      assign src_res[gi] =
         (src_idx[gi] == '0)                             ? src_val[gi]  :
         (mem_fwd_valid && (mem_fwd_rd == src_idx[gi]))  ? mem_fwd_data :
         (wb_fwd_valid  && (wb_fwd_rd  == src_idx[gi]))  ? wb_fwd_data  :
                                                           src_val[gi];
   end

   assign hazard = in_valid && valid_reg && is_load_reg && (rd_reg != '0) &&
                   ((in_rs1 == rd_reg) || (!in_use_imm && (in_rs2 == rd_reg)));

   assign in_ready = !rst && !flush && !hazard && (!valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg        <= 1'b0;
         opcode_reg       <= '0;
         rs1_reg          <= '0;
         rs2_reg          <= '0;
         rd_reg           <= '0;
         rs1_val_reg      <= '0;
         rs2_val_reg      <= '0;
         imm_reg          <= '0;
         use_imm_reg      <= 1'b0;
         is_load_reg      <= 1'b0;
         bubble_count_reg <= '0;
      end else if (flush) begin
         valid_reg <= 1'b0;
      end else if (accept) begin
         valid_reg   <= 1'b1;
         opcode_reg  <= in_opcode;
         rs1_reg     <= in_rs1;
         rs2_reg     <= in_rs2;
         rd_reg      <= in_rd;
         rs1_val_reg <= in_rs1_val;
         rs2_val_reg <= in_rs2_val;
         imm_reg     <= in_imm;
         use_imm_reg <= in_use_imm;
         is_load_reg <= in_is_load;
      end else if (hazard && out_ready) begin
         valid_reg <= 1'b0;
         if (bubble_count_reg != 16'hFFFF) begin
            bubble_count_reg <= bubble_count_reg + 16'd1;
         end
      end else if (valid_reg && out_ready) begin
         valid_reg <= 1'b0;
      end else if (valid_reg) begin
         // Capture forwarded values while stalled; the producer may retire before we issue.
         rs1_val_reg <= src_res[0];
         rs2_val_reg <= src_res[1];
      end
   end

   assign ex_valid     = valid_reg;
   assign alu_a        = src_res[0];
   assign alu_b        = use_imm_reg ? imm_reg : src_res[1];
   assign alu_opcode   = opcode_reg;
   assign ex_rd        = rd_reg;
   assign ex_is_load   = is_load_reg;
   assign bubble_count = bubble_count_reg;

endmodule

// File: tb/tb_ex_issue_reg.sv
// Bench for ex_issue_reg: a transaction-level model checked every cycle, plus
// directed vectors with hand-computed literal expectations.
module tb_ex_issue_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic [31:0] in_rs1_val, in_rs2_val, in_imm;
   logic        in_use_imm, in_is_load;
   logic        flush;
   logic        mem_fwd_valid;
   logic [4:0]  mem_fwd_rd;
   logic [31:0] mem_fwd_data;
   logic        wb_fwd_valid;
   logic [4:0]  wb_fwd_rd;
   logic [31:0] wb_fwd_data;
   logic        out_ready;
   logic        ex_valid;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [4:0]  ex_rd;
   logic        ex_is_load;
   logic [15:0] bubble_count;

   int checks   = 0;
   int failures = 0;

   ex_issue_reg #(.XLEN(32), .REGW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
      .in_use_imm(in_use_imm), .in_is_load(in_is_load), .flush(flush),
      .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
      .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
      .out_ready(out_ready), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
      .alu_opcode(alu_opcode), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 20)
            $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] v1, v2, imm;
      logic        use_imm, is_load;
   } instr_t;

   instr_t m_ins = '{default: 0};
   bit     m_valid = 1'b0;
   int     m_bubbles = 0;
   bit     started = 1'b0;

   function automatic logic [31:0] fwd_value(input logic [4:0] idx, input logic [31:0] regval);
      if (idx == 5'd0) return regval;
      if (mem_fwd_valid && mem_fwd_rd == idx) return mem_fwd_data;
      if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
      return regval;
   endfunction

   function automatic bit load_use();
      bit dep;
      dep = (in_rs1 == m_ins.rd) || (!in_use_imm && in_rs2 == m_ins.rd);
      return in_valid && m_valid && m_ins.is_load && (m_ins.rd != 5'd0) && dep;
   endfunction

   function automatic bit exp_ready();
      return !rst && !flush && !load_use() && (!m_valid || out_ready);
   endfunction

   function automatic instr_t cur_input();
      instr_t t;
      t.op = in_opcode; t.rs1 = in_rs1; t.rs2 = in_rs2; t.rd = in_rd;
      t.v1 = in_rs1_val; t.v2 = in_rs2_val; t.imm = in_imm;
      t.use_imm = in_use_imm; t.is_load = in_is_load;
      return t;
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      if (rst) begin
         m_valid   <= 1'b0;
         m_ins     <= '{default: 0};
         m_bubbles <= 0;
      end else if (flush) begin
         m_valid <= 1'b0;
      end else if (in_valid && exp_ready()) begin
         m_valid <= 1'b1;
         m_ins   <= cur_input();
      end else if (load_use() && out_ready) begin
         m_valid   <= 1'b0;
         m_bubbles <= (m_bubbles < 65535) ? m_bubbles + 1 : 65535;
      end else if (out_ready) begin
         m_valid <= 1'b0;
      end else if (m_valid) begin
         m_ins.v1 <= fwd_value(m_ins.rs1, m_ins.v1);
         m_ins.v2 <= fwd_value(m_ins.rs2, m_ins.v2);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("cmp_ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
         chk("cmp_in_ready", {31'd0, in_ready}, {31'd0, exp_ready()});
         chk("cmp_alu_a", alu_a, fwd_value(m_ins.rs1, m_ins.v1));
         chk("cmp_alu_b", alu_b, m_ins.use_imm ? m_ins.imm : fwd_value(m_ins.rs2, m_ins.v2));
         chk("cmp_opcode", {28'd0, alu_opcode}, {28'd0, m_ins.op});
         chk("cmp_ex_rd", {27'd0, ex_rd}, {27'd0, m_ins.rd});
         chk("cmp_ex_is_load", {31'd0, ex_is_load}, {31'd0, m_ins.is_load});
         chk("cmp_bubbles", {16'd0, bubble_count}, 32'(m_bubbles));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; in_opcode = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
      in_rs1_val = 0; in_rs2_val = 0; in_imm = 0; in_use_imm = 0; in_is_load = 0;
      flush = 0; out_ready = 1;
      mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
      wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic use_imm, input logic is_load);
      in_valid = 1; in_opcode = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_rs1_val = v1; in_rs2_val = v2; in_imm = imm;
      in_use_imm = use_imm; in_is_load = is_load;
      $display("drive op=%0d rs1=%0d rs2=%0d rd=%0d v1=0x%0h v2=0x%0h imm=0x%0h use_imm=%0d load=%0d",
               op, rs1, rs2, rd, v1, v2, imm, use_imm, is_load);
   endtask

   initial begin
      idle();
      rst = 1;
      tick();
      tick();
      settle();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_bubbles", {16'd0, bubble_count}, 32'd0);
      rst = 0;

      // Plain ADD, no forwarding
      issue(4'd0, 5'd1, 5'd2, 5'd6, 32'd15, 32'd10, 32'd0, 1'b0, 1'b0);
      tick();
      in_valid = 0;
      settle();
      chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
      chk("add_alu_a", alu_a, 32'd15);
      chk("add_alu_b", alu_b, 32'd10);
      chk("add_opcode", {28'd0, alu_opcode}, 32'd0);
      tick();

      // Forwarding priority on a held SUB
      issue(4'd1, 5'd3, 5'd0, 5'd8, 32'd7, 32'd0, 32'd5, 1'b1, 1'b0);
      tick();
      in_valid = 0; out_ready = 0;
      mem_fwd_valid = 1; mem_fwd_rd = 5'd3; mem_fwd_data = 32'd20;
      wb_fwd_valid = 1;  wb_fwd_rd = 5'd3;  wb_fwd_data = 32'd99;
      settle();
      chk("fwd_mem_prio", alu_a, 32'd20);
      chk("fwd_imm_b", alu_b, 32'd5);
      mem_fwd_valid = 0;
      #1;
      chk("fwd_wb", alu_a, 32'd99);
      tick();
      wb_fwd_valid = 0;
      settle();
      chk("fwd_wb_retained", alu_a, 32'd99);
      out_ready = 1;
      tick();

      // Index 0 never forwarded
      issue(4'd3, 5'd0, 5'd0, 5'd9, 32'h55, 32'h66, 32'd0, 1'b0, 1'b0);
      tick();
      in_valid = 0; out_ready = 0;
      mem_fwd_valid = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd20;
      wb_fwd_valid = 1;  wb_fwd_rd = 5'd0;  wb_fwd_data = 32'd99;
      settle();
      chk("x0_alu_a", alu_a, 32'h55);
      chk("x0_alu_b", alu_b, 32'h66);
      out_ready = 1; mem_fwd_valid = 0; wb_fwd_valid = 0;
      tick();

      // Load-use hazard via rs2
      issue(4'd0, 5'd1, 5'd0, 5'd4, 32'd100, 32'd0, 32'd4, 1'b1, 1'b1);
      tick();
      issue(4'd2, 5'd1, 5'd4, 5'd10, 32'hF0, 32'd0, 32'd0, 1'b0, 1'b0);
      settle();
      chk("lu_in_ready_low", {31'd0, in_ready}, 32'd0);
      chk("lu_load_held", {31'd0, ex_is_load}, 32'd1);
      tick();
      settle();
      chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
      chk("lu_in_ready_high", {31'd0, in_ready}, 32'd1);
      chk("lu_bubbles", {16'd0, bubble_count}, 32'd1);
      tick();
      in_valid = 0;
      wb_fwd_valid = 1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'h3C;
      settle();
      chk("lu_and_valid", {31'd0, ex_valid}, 32'd1);
      chk("lu_and_a", alu_a, 32'hF0);
      chk("lu_and_b_wb", alu_b, 32'h3C);
      chk("lu_and_op", {28'd0, alu_opcode}, 32'd2);
      tick();
      wb_fwd_valid = 0;

      // Same dependency through rs2 but immediate operand: no bubble
      issue(4'd0, 5'd1, 5'd0, 5'd4, 32'd100, 32'd0, 32'd4, 1'b1, 1'b1);
      tick();
      issue(4'd2, 5'd1, 5'd4, 5'd10, 32'hF0, 32'd0, 32'd7, 1'b1, 1'b0);
      settle();
      chk("imm_no_hazard", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 0;
      settle();
      chk("imm_and_valid", {31'd0, ex_valid}, 32'd1);
      chk("imm_and_b", alu_b, 32'd7);
      chk("imm_bubbles", {16'd0, bubble_count}, 32'd1);
      tick();

      // Back-pressure hold with WB data present only on the first cycle
      issue(4'd4, 5'd5, 5'd0, 5'd11, 32'd1, 32'd0, 32'h40, 1'b1, 1'b0);
      tick();
      issue(4'd0, 5'd1, 5'd2, 5'd12, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0);
      out_ready = 0;
      wb_fwd_valid = 1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h8;
      settle();
      chk("hold1_a", alu_a, 32'h8);
      chk("hold1_ready", {31'd0, in_ready}, 32'd0);
      tick();
      wb_fwd_valid = 0;
      settle();
      chk("hold2_a", alu_a, 32'h8);
      chk("hold2_ready", {31'd0, in_ready}, 32'd0);
      tick();
      settle();
      chk("hold3_a", alu_a, 32'h8);
      chk("hold3_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 0; out_ready = 1;
      tick();

      // Flush refuses input
      issue(4'd0, 5'd1, 5'd2, 5'd13, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
      flush = 1;
      settle();
      chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      flush = 0; in_valid = 0;
      settle();
      chk("flush_ex_valid", {31'd0, ex_valid}, 32'd0);

      // Reset in the middle of a hold
      issue(4'd1, 5'd1, 5'd2, 5'd12, 32'h1234, 32'h5, 32'd0, 1'b0, 1'b0);
      tick();
      in_valid = 0; out_ready = 0;
      settle();
      chk("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
      rst = 1;
      tick();
      settle();
      chk("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("mid_rst_a", alu_a, 32'd0);
      chk("mid_rst_b", alu_b, 32'd0);
      chk("mid_rst_op", {28'd0, alu_opcode}, 32'd0);
      chk("mid_rst_rd", {27'd0, ex_rd}, 32'd0);
      chk("mid_rst_bubbles", {16'd0, bubble_count}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd0);
      rst = 0; out_ready = 1;

      // Saturation: a self-dependent load alternates accept / bubble
      in_valid = 1; in_opcode = 4'd0; in_rs1 = 5'd7; in_rs2 = 5'd0; in_rd = 5'd7;
      in_rs1_val = 32'd0; in_rs2_val = 32'd0; in_imm = 32'd0; in_use_imm = 1; in_is_load = 1;
      $display("drive repeated load rs1=7 rd=7 for 65541 bubbles");
      for (int i = 0; i < 20; i++) tick();
      settle();
      chk("sat_count_10", {16'd0, bubble_count}, 32'd10);
      for (int i = 0; i < 131062; i++) tick();
      in_valid = 0;
      settle();
      chk("sat_count_max", {16'd0, bubble_count}, 32'h0000FFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
